// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
    localparam int unsigned DATA_W = 32;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch/jump redirect, variable-latency data-memory access
// with timeout abort, pipeline stall generation and the MEM/WB register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic [31:0] PC_in,
    input  logic [25:0] Jump_immed_in,
    input  logic        Zero_in,
    input  logic [31:0] ALURes_in,
    input  logic [31:0] Data_Write_in,
    input  logic [31:0] ExtOut_in,
    input  logic [4:0]  Reg_Write_in,
    mem_stage_if.master dmem,
    output logic        stall_out,
    output logic        pc_redirect_out,
    output logic [31:0] pc_target_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [31:0] MemData_out,
    output logic [31:0] ALURes_out,
    output logic [4:0]  Reg_Write_out,
    output logic        bus_err_out
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_bus_err;

    logic        w_mem_op;
    logic        w_in_wait;
    logic        w_timeout;
    logic        w_abort;
    logic        w_stall;
    logic        w_take_branch;
    logic        w_redirect;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;

    assign w_mem_op  = MemRead_in | MemWrite_in;
    assign w_in_wait = (r_state == S_WAIT);
    assign w_timeout = w_in_wait & (r_cnt == LIMIT);
    // An ack on the limit cycle completes the access instead of aborting it.
    assign w_abort   = w_timeout & ~dmem.dmem_ack;
    assign w_stall   = ((r_state == S_IDLE) & w_mem_op)
                     | (w_in_wait & ~dmem.dmem_ack & ~w_timeout);

    assign w_take_branch = Branch_in & Zero_in;
    assign w_redirect    = ~w_stall & (Jump_in | w_take_branch);
    assign w_branch_tgt  = PC_in + {ExtOut_in[29:0], 2'b00};
    assign w_jump_tgt    = {PC_in[31:28], Jump_immed_in, 2'b00};

    assign stall_out       = w_stall;
    assign pc_redirect_out = w_redirect;
    assign pc_target_out   = !w_redirect ? 32'd0 :
                             (Jump_in ? w_jump_tgt : w_branch_tgt);

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign bus_err_out     = r_bus_err;

    // Access FSM; request and latched bus fields are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_in;
                        r_addr  <= ALURes_in;
                        r_wdata <= Data_Write_in;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= S_IDLE;
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, data fields hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemtoReg_out  <= 1'b0;
            RegWrite_out  <= 1'b0;
            MemData_out   <= '0;
            ALURes_out    <= '0;
            Reg_Write_out <= '0;
        end else if (w_stall) begin
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
        end else begin
            MemtoReg_out  <= MemtoReg_in;
            RegWrite_out  <= RegWrite_in & ~w_abort;
            MemData_out   <= dmem.dmem_rdata;
            ALURes_out    <= ALURes_in;
            Reg_Write_out <= Reg_Write_in;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for redirect/MEM-WB behaviour,
// hand sequences for memory accesses, timeout abort and asynchronous reset.
module tb_mem_stage;
    logic        clk;
    logic        rst_n;
    logic        MemtoReg_in, RegWrite_in, Branch_in, Jump_in;
    logic        MemWrite_in, MemRead_in, Zero_in;
    logic [31:0] PC_in, ALURes_in, Data_Write_in, ExtOut_in;
    logic [25:0] Jump_immed_in;
    logic [4:0]  Reg_Write_in;
    logic        stall_out, pc_redirect_out;
    logic [31:0] pc_target_out;
    logic        MemtoReg_out, RegWrite_out, bus_err_out;
    logic [31:0] MemData_out, ALURes_out;
    logic [4:0]  Reg_Write_out;

    int total = 0;
    int bad   = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemtoReg_in    (MemtoReg_in),
        .RegWrite_in    (RegWrite_in),
        .Branch_in      (Branch_in),
        .Jump_in        (Jump_in),
        .MemWrite_in    (MemWrite_in),
        .MemRead_in     (MemRead_in),
        .PC_in          (PC_in),
        .Jump_immed_in  (Jump_immed_in),
        .Zero_in        (Zero_in),
        .ALURes_in      (ALURes_in),
        .Data_Write_in  (Data_Write_in),
        .ExtOut_in      (ExtOut_in),
        .Reg_Write_in   (Reg_Write_in),
        .dmem           (bus),
        .stall_out      (stall_out),
        .pc_redirect_out(pc_redirect_out),
        .pc_target_out  (pc_target_out),
        .MemtoReg_out   (MemtoReg_out),
        .RegWrite_out   (RegWrite_out),
        .MemData_out    (MemData_out),
        .ALURes_out     (ALURes_out),
        .Reg_Write_out  (Reg_Write_out),
        .bus_err_out    (bus_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br, jmp, zero, rw, m2r;
        logic [31:0] pc, ext, alu;
        logic [25:0] ji;
        logic [4:0]  rd;
        logic        exp_redir;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemtoReg_in = 1'b0; RegWrite_in = 1'b0; Branch_in = 1'b0; Jump_in = 1'b0;
        MemWrite_in = 1'b0; MemRead_in = 1'b0; Zero_in = 1'b0;
        PC_in = '0; ALURes_in = '0; Data_Write_in = '0; ExtOut_in = '0;
        Jump_immed_in = '0; Reg_Write_in = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    endtask

    // Runs one access; ack_at = WAIT cycle (1..4) carrying the ack, 0 = never.
    task automatic access(input string nm, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at,
                          input logic [31:0] rdata, input logic exp_err);
        logic exp_stall;
        logic done;
        @(negedge clk);
        MemRead_in = ~wr; MemWrite_in = wr; RegWrite_in = 1'b1; MemtoReg_in = ~wr;
        ALURes_in = addr; Data_Write_in = wdata; Reg_Write_in = 5'd7;
        Branch_in = 1'b1; Zero_in = 1'b1; PC_in = 32'h100; ExtOut_in = 32'h1;
        #1;
        chk({nm, " idle stall"}, 32'(stall_out), 32'd1);
        chk({nm, " redirect masked"}, 32'(pc_redirect_out), 32'd0);
        @(posedge clk); #1;
        chk({nm, " req"}, 32'(bus.dmem_req), 32'd1);
        chk({nm, " addr"}, bus.dmem_addr, addr);
        chk({nm, " we"}, 32'(bus.dmem_we), 32'(wr));
        if (wr) chk({nm, " wdata"}, bus.dmem_wdata, wdata);
        chk({nm, " bubble"}, 32'(RegWrite_out), 32'd0);
        done = 1'b0;
        for (int w = 1; w <= 4 && !done; w++) begin
            bus.dmem_ack   = (w == ack_at);
            bus.dmem_rdata = (w == ack_at) ? rdata : 32'hBAD0_0000;
            exp_stall = (w != ack_at) && (w != 4);
            #1;
            chk({nm, " wait stall"}, 32'(stall_out), 32'(exp_stall));
            if (!exp_stall) chk({nm, " redirect at release"}, pc_target_out, 32'h104);
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
            if (!exp_stall) begin
                done = 1'b1;
                chk({nm, " req dropped"}, 32'(bus.dmem_req), 32'd0);
                chk({nm, " regwrite"}, 32'(RegWrite_out), (ack_at != 0) ? 32'd1 : 32'd0);
                if (ack_at != 0 && !wr) chk({nm, " memdata"}, MemData_out, rdata);
                chk({nm, " bus_err"}, 32'(bus_err_out), 32'(exp_err));
            end else begin
                chk({nm, " wait bubble"}, 32'(RegWrite_out), 32'd0);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("reset req", 32'(bus.dmem_req), 32'd0);
        chk("reset regwrite", 32'(RegWrite_out), 32'd0);
        chk("reset bus_err", 32'(bus_err_out), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        //        br   jmp  zero rw   m2r  pc            ext           alu           ji           rd     redir tgt
        vecs[0] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,       32'h0,        32'h1234,     26'h0,       5'd5,  1'b0, 32'h0};
        vecs[1] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h100,     32'hFFFFFFFE, 32'h55,       26'h0,       5'd0,  1'b1, 32'hF8};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h100,     32'hFFFFFFFE, 32'h66,       26'h0,       5'd1,  1'b0, 32'h0};
        vecs[3] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h40000000,32'h0,        32'h77,       26'h10,      5'd2,  1'b1, 32'h40000040};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b1,1'b1,32'h40000000,32'h1,        32'hCAFEF00D, 26'h3FFFFFF, 5'd31, 1'b1, 32'h4FFFFFFC};
        vecs[5] = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'hFFFFFFF0,32'h8,        32'h1234,     26'h0,       5'd9,  1'b1, 32'h10};

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            Branch_in = vecs[i].br; Jump_in = vecs[i].jmp; Zero_in = vecs[i].zero;
            RegWrite_in = vecs[i].rw; MemtoReg_in = vecs[i].m2r; PC_in = vecs[i].pc;
            ExtOut_in = vecs[i].ext; ALURes_in = vecs[i].alu;
            Jump_immed_in = vecs[i].ji; Reg_Write_in = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d stall", i), 32'(stall_out), 32'd0);
            chk($sformatf("vec%0d redirect", i), 32'(pc_redirect_out), 32'(vecs[i].exp_redir));
            chk($sformatf("vec%0d target", i), pc_target_out, vecs[i].exp_tgt);
            @(posedge clk); #1;
            chk($sformatf("vec%0d regwrite", i), 32'(RegWrite_out), 32'(vecs[i].rw));
            chk($sformatf("vec%0d memtoreg", i), 32'(MemtoReg_out), 32'(vecs[i].m2r));
            chk($sformatf("vec%0d alures", i), ALURes_out, vecs[i].alu);
            chk($sformatf("vec%0d regdst", i), 32'(Reg_Write_out), 32'(vecs[i].rd));
        end
        @(negedge clk);
        idle_inputs();

        access("load3", 1'b0, 32'h40, 32'h0, 4, 32'hDEADBEEF, 1'b0);
        access("load1", 1'b0, 32'h80, 32'h0, 2, 32'h13572468, 1'b0);
        access("ackdrop", 1'b0, 32'h84, 32'h0, 1, 32'h0000ABCD, 1'b0);

        // Ack outside WAIT is ignored.
        @(negedge clk);
        bus.dmem_ack = 1'b1;
        #1;
        chk("stray ack stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("stray ack req", 32'(bus.dmem_req), 32'd0);
        @(negedge clk);
        bus.dmem_ack = 1'b0;

        access("store timeout", 1'b1, 32'h200, 32'hA5A5, 0, 32'h0, 1'b1);
        @(posedge clk); #1;
        chk("bus_err sticky", 32'(bus_err_out), 32'd1);

        // Non-memory op leaves known data in MEM/WB before the mid-access reset.
        @(negedge clk);
        RegWrite_in = 1'b1; ALURes_in = 32'h1234; Reg_Write_in = 5'd5;
        @(posedge clk); #1;
        chk("pre-reset alures", ALURes_out, 32'h1234);
        @(negedge clk);
        RegWrite_in = 1'b0; MemRead_in = 1'b1; ALURes_in = 32'h300;
        @(posedge clk); #1;
        chk("mid-wait req", 32'(bus.dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset req", 32'(bus.dmem_req), 32'd0);
        chk("async reset addr", bus.dmem_addr, 32'h0);
        chk("async reset alures", ALURes_out, 32'h0);
        chk("async reset regdst", 32'(Reg_Write_out), 32'd0);
        chk("async reset bus_err", 32'(bus_err_out), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        chk("post-reset stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        chk("post-reset req", 32'(bus.dmem_req), 32'd0);
        chk("post-reset bus_err", 32'(bus_err_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
